register_file: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the MIPS-style datapath.
- Two combinational read ports, A (indexed by rs) and B (indexed by rt), plus one synchronous write port (rd, writedata, regwrite).
- Sits between instruction decode, which supplies rs/rt/rd, and the ALU operand muxes; writeback drives writedata and regwrite.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 23 ++
 rtl/register_file.sv | 58 +++++
 tb/tb_register_file.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, index/word types and the hardwired-zero index for the register file
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: index decode, r0 forcing, write-through bypass
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  reg_idx_t                        raddr_i,
    input  logic                            bypass_en_i,
    input  reg_idx_t                        waddr_i,
    input  word_t                           wdata_i,
    output word_t                           rdata_o
);

    // r0 wins over bypass so a write aimed at r0 is never visible
    always_comb begin
        rdata_o = regs_i[raddr_i];
        if (raddr_i == ZERO_REG) begin
            rdata_o = '0;
        end else if (bypass_en_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two combinational read ports and one synchronous write port
module register_file
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rs,
    input  reg_idx_t rt,
    input  reg_idx_t rd,
    input  word_t    writedata,
    input  logic     regwrite,
    output word_t    A,
    output word_t    B
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
    logic                            write_en;

    assign write_en = regwrite && (rd != ZERO_REG);

    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[rd] = writedata;
        end
    end

    // Reset loads each register with its own index; it overrides any write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port u_port_a (
        .regs_i      (regs_q),
        .raddr_i     (rs),
        .bypass_en_i (regwrite && !rst),
        .waddr_i     (rd),
        .wdata_i     (writedata),
        .rdata_o     (A)
    );

    regfile_read_port u_port_b (
        .regs_i      (regs_q),
        .raddr_i     (rt),
        .bypass_en_i (regwrite && !rst),
        .waddr_i     (rd),
        .wdata_i     (writedata),
        .rdata_o     (B)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed scoreboard bench for register_file
module tb_register_file;
    import regfile_pkg::*;

    logic     clk;
    logic     rst;
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;
    word_t    writedata;
    logic     regwrite;
    word_t    A;
    word_t    B;

    int n_pass;
    int n_total;

    word_t exp_a_q[$];
    word_t exp_b_q[$];

    register_file dut (
        .clk       (clk),
        .rst       (rst),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .writedata (writedata),
        .regwrite  (regwrite),
        .A         (A),
        .B         (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input word_t obs, input word_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive read indices, queue the expected outputs, then sample at the falling edge
    task automatic check_ab(input string tag, input reg_idx_t ia, input reg_idx_t ib,
                            input word_t ea, input word_t eb);
        word_t oa;
        word_t ob;
        rs = ia;
        rt = ib;
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        @(negedge clk);
        if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
            n_total++;
            $error("FAIL %s: scoreboard empty, observed %h/%h", tag, A, B);
        end else begin
            oa = exp_a_q.pop_front();
            ob = exp_b_q.pop_front();
            cmp({tag, ".A"}, A, oa);
            cmp({tag, ".B"}, B, ob);
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        rs        = '0;
        rt        = '0;
        rd        = '0;
        writedata = '0;
        regwrite  = 1'b0;

        tick();
        rst = 1'b0;
        check_ab("reset01", 5'd0, 5'd1, 32'd0, 32'd1);
        check_ab("reset23", 5'd2, 5'd3, 32'd2, 32'd3);

        rd = 5'd3; writedata = 32'd100; regwrite = 1'b1;
        check_ab("wr_pre", 5'd4, 5'd5, 32'd4, 32'd5);
        tick();
        check_ab("wr_post", 5'd4, 5'd5, 32'd4, 32'd5);
        regwrite = 1'b0;
        check_ab("readback", 5'd4, 5'd3, 32'd4, 32'd100);

        rd = 5'd6; writedata = 32'd100; regwrite = 1'b1;
        check_ab("bypass_pre", 5'd6, 5'd5, 32'd100, 32'd5);
        tick();
        regwrite = 1'b0;
        check_ab("bypass_post", 5'd6, 5'd5, 32'd100, 32'd5);

        rd = 5'd0; writedata = 32'hDEADBEEF; regwrite = 1'b1;
        check_ab("r0_pre", 5'd7, 5'd0, 32'd7, 32'd0);
        tick();
        check_ab("r0_nobypass", 5'd0, 5'd0, 32'd0, 32'd0);
        regwrite = 1'b0;
        check_ab("r0_post", 5'd0, 5'd8, 32'd0, 32'd8);

        rd = 5'd9; writedata = 32'h0000_1234; regwrite = 1'b1;
        check_ab("dual_bypass", 5'd9, 5'd9, 32'h0000_1234, 32'h0000_1234);
        rst = 1'b1;
        check_ab("rst_nobypass", 5'd9, 5'd9, 32'd9, 32'd9);

        rd = 5'd7; writedata = 32'd55;
        tick();
        rst = 1'b0; regwrite = 1'b0;
        check_ab("rst_prio", 5'd7, 5'd3, 32'd7, 32'd3);
        check_ab("rst_restore", 5'd6, 5'd9, 32'd6, 32'd9);

        regwrite = 1'b1;
        for (int i = 1; i < NUM_REGS; i++) begin
            rd        = reg_idx_t'(i);
            writedata = word_t'(i * 16 + 1);
            tick();
        end
        regwrite = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            int j;
            word_t ea;
            word_t eb;
            j  = NUM_REGS - 1 - i;
            ea = (i == 0) ? 32'd0 : word_t'(i * 16 + 1);
            eb = (j == 0) ? 32'd0 : word_t'(j * 16 + 1);
            check_ab($sformatf("sweep%0d", i), reg_idx_t'(i), reg_idx_t'(j), ea, eb);
        end
        check_ab("same_idx", 5'd5, 5'd5, 32'd81, 32'd81);

        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            n_total++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_a_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
